time_counter: RTL and testbench
===============================

TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are listed clock and reset first.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 ena_1hz  input  1  1 Hz square wave from the frequency divider, synchronous to clk, 50% duty.
REQ-005 ena_5hz  input  1  5 Hz square wave from the frequency divider, synchronous to clk; used for auto-repeat.
REQ-006 btn_mode  input  1  debounced mode button, active-high level, synchronous to clk.
REQ-007 btn_inc  input  1  debounced increment button, active-high level, synchronous to clk.
REQ-008 hour_bcd  output  8  hours, two BCD digits, 00-23.
REQ-009 min_bcd  output  8  minutes, two BCD digits, 00-59.
REQ-010 sec_bcd  output  8  seconds, two BCD digits, 00-59.
REQ-011 mode  output  2  current state: 00 RUN, 01 SET_HOUR, 10 SET_MIN; 11 never driven.
REQ-012 tick  output  1  one-cycle pulse on every detected ena_1hz rising edge, in every mode.

Function
REQ-013 Edge detection SHALL register each of ena_1hz, ena_5hz, btn_mode and btn_inc once.
- Rising edge = current high AND registered value low.
- Detected one clk after the input transition.
REQ-014 tick SHALL be high for exactly one cycle per ena_1hz rising edge, i.e. once per second.
REQ-015 In RUN, each 1 Hz edge SHALL increment sec_bcd, effective on the cycle tick is high.
REQ-016 Carry chain:
- sec 59 -> 00 with min +1.
- min 59 -> 00 with hour +1.
- hour 23 -> 00.
- All carries settle in the same cycle: 23:59:59 -> 00:00:00 in one step.
REQ-017 Each BCD digit SHALL stay in range: ones 0-9; tens 0-5 for sec/min, 0-2 for hour; hour never exceeds 23.
REQ-018 State machine on btn_mode rising edge:
- RUN -> SET_HOUR.
- SET_HOUR -> SET_MIN.
- SET_MIN -> RUN, with sec_bcd cleared to 00 in the same cycle.
REQ-019 In SET_HOUR and SET_MIN, 1 Hz edges SHALL not modify sec/min/hour; tick still pulses.
REQ-020 Increment in a set state:
- btn_inc rising edge increments the selected field by 1.
- While btn_inc stays high, each ena_5hz rising edge increments it again (auto-repeat).
REQ-021 Set-state wrap SHALL be min 59 -> 00 and hour 23 -> 00 with no carry into any other field.
REQ-022 btn_inc SHALL have no effect in RUN.
REQ-023 Simultaneous events:
- A btn_mode edge and a 1 Hz edge in the same cycle in RUN: the second increment is applied and the state advances to SET_HOUR.
- A btn_mode edge and an increment event in the same cycle in a set state: the increment applies to the field of the current state, and the state then advances.
- A btn_inc edge and an ena_5hz edge in the same cycle: exactly one increment.
REQ-024 All outputs SHALL be registered; there is no combinational path from inputs to outputs.

Reset
REQ-025 While rst_n is low:
- hour_bcd, min_bcd and sec_bcd = 8'h00.
- mode = 00 (RUN); tick = 0.
- All edge-detect registers = 0.
REQ-026 Reset SHALL take effect immediately on rst_n low, including mid-set or mid-carry, and discard any pending edge.
REQ-027 After rst_n is released, an input already high SHALL count as a rising edge on the first clk edge.

Verification
REQ-028 Reset: drive random time, assert rst_n low mid-cycle -> outputs 00:00:00, mode 00, tick 0 immediately.
REQ-029 Rollover: preload 23:59:59 via the set sequence, then one ena_1hz rise -> 00:00:00 in one cycle; tick high for 1 cycle.
REQ-030 Set sequence: from RUN, btn_mode pulse x1, btn_inc pulse x5 -> hour 05. Then btn_mode x1, btn_inc held for 3 ena_5hz rises -> min 04. Then btn_mode x1 -> mode 00, sec 00.
REQ-031 Set wrap: in SET_MIN at 59, one btn_inc pulse -> min 00 and hour unchanged; in SET_HOUR at 23 -> hour 00.
REQ-032 Collision: at 00:00:59 in RUN, btn_mode rise in the same cycle as an ena_1hz rise -> time 00:01:00, mode 01.
REQ-033 Pause: in SET_HOUR, 3 ena_1hz rises -> sec unchanged, 3 tick pulses.

Source files
------------

// File: rtl/time_counter_if.sv
// Signal bundle between the frequency divider / button logic and the time counter.
interface time_counter_if;
  logic       ena_1hz;
  logic       ena_5hz;
  logic       btn_mode;
  logic       btn_inc;
  logic [7:0] hour_bcd;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic [1:0] mode;
  logic       tick;

  modport master (
    output ena_1hz, ena_5hz, btn_mode, btn_inc,
    input  hour_bcd, min_bcd, sec_bcd, mode, tick
  );

  modport slave (
    input  ena_1hz, ena_5hz, btn_mode, btn_inc,
    output hour_bcd, min_bcd, sec_bcd, mode, tick
  );
endinterface

// File: rtl/time_counter.sv
// BCD hh:mm:ss clock with a RUN / SET_HOUR / SET_MIN mode machine and
// auto-repeat increment while the increment button is held.
module time_counter (
  input  logic          clk,
  input  logic          rst_n,
  time_counter_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } state_t;

  state_t     state_q, state_d;
  logic       ena_1hz_q, ena_5hz_q, btn_mode_q, btn_inc_q;
  logic       rise_1hz, rise_5hz, rise_mode, rise_inc, inc_event;
  logic [7:0] hour_q, min_q, sec_q;
  logic [7:0] hour_d, min_d, sec_d;
  logic       tick_q;

  // Two-digit BCD increment that wraps to 00 after the given last value.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    logic [7:0] r;
    if (v == last)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  assign rise_1hz  = bus.ena_1hz  & ~ena_1hz_q;
  assign rise_5hz  = bus.ena_5hz  & ~ena_5hz_q;
  assign rise_mode = bus.btn_mode & ~btn_mode_q;
  assign rise_inc  = bus.btn_inc  & ~btn_inc_q;
  // A press edge and a coincident repeat edge merge into a single increment.
  assign inc_event = rise_inc | (bus.btn_inc & rise_5hz);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    case (state_q)
      RUN: begin
        if (rise_1hz) begin
          sec_d = bcd_inc(sec_q, 8'h59);
          if (sec_q == 8'h59) begin
            min_d = bcd_inc(min_q, 8'h59);
            if (min_q == 8'h59)
              hour_d = bcd_inc(hour_q, 8'h23);
          end
        end
        if (rise_mode)
          state_d = SET_HOUR;
      end
      SET_HOUR: begin
        if (inc_event)
          hour_d = bcd_inc(hour_q, 8'h23);
        if (rise_mode)
          state_d = SET_MIN;
      end
      SET_MIN: begin
        if (inc_event)
          min_d = bcd_inc(min_q, 8'h59);
        if (rise_mode) begin
          sec_d   = 8'h00;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      ena_1hz_q  <= 1'b0;
      ena_5hz_q  <= 1'b0;
      btn_mode_q <= 1'b0;
      btn_inc_q  <= 1'b0;
      hour_q     <= 8'h00;
      min_q      <= 8'h00;
      sec_q      <= 8'h00;
      tick_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q    <= state_d;
      ena_1hz_q  <= bus.ena_1hz;
      ena_5hz_q  <= bus.ena_5hz;
      btn_mode_q <= bus.btn_mode;
      btn_inc_q  <= bus.btn_inc;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      tick_q     <= rise_1hz;
    end
  end

  assign bus.hour_bcd = hour_q;
  assign bus.min_bcd  = min_q;
  assign bus.sec_bcd  = sec_q;
  assign bus.mode     = state_q;
  assign bus.tick     = tick_q;

endmodule

// File: tb/tb_time_counter.sv
// Scoreboard bench for time_counter: a seconds-of-day reference model predicts
// each cycle's outputs, a monitor compares them, plus directed boundary checks.
module tb_time_counter;

  typedef struct packed {
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] s;
    logic [1:0] mode;
    logic       tick;
  } exp_t;

  logic clk;
  logic rst_n;
  time_counter_if bus();

  time_counter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];

  // Reference model state: plain integers, not BCD.
  int   m_h, m_m, m_s, m_mode;
  logic p_e1, p_e5, p_m, p_i;

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] req);
    n_checks++;
    if (got === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, got, req);
  endtask

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_mode = 0;
    p_e1 = 1'b0; p_e5 = 1'b0; p_m = 1'b0; p_i = 1'b0;
  endtask

  // Apply one cycle of input levels, predict the post-edge outputs, and
  // return 2 time units after the edge.
  task automatic step(input logic e1, input logic e5, input logic m, input logic i);
    logic r1, r5, rm, ri, inc;
    int   t;
    exp_t e;
    bus.ena_1hz = e1; bus.ena_5hz = e5; bus.btn_mode = m; bus.btn_inc = i;
    r1  = e1 & ~p_e1;
    r5  = e5 & ~p_e5;
    rm  = m & ~p_m;
    ri  = i & ~p_i;
    inc = ri | (i & r5);
    case (m_mode)
      0: begin
        if (r1) begin
          t   = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
          m_h = t / 3600;
          m_m = (t / 60) % 60;
          m_s = t % 60;
        end
        if (rm) m_mode = 1;
      end
      1: begin
        if (inc) m_h = (m_h + 1) % 24;
        if (rm) m_mode = 2;
      end
      default: begin
        if (inc) m_m = (m_m + 1) % 60;
        if (rm) begin m_s = 0; m_mode = 0; end
      end
    endcase
    p_e1 = e1; p_e5 = e5; p_m = m; p_i = i;
    e.h = to_bcd(m_h); e.m = to_bcd(m_m); e.s = to_bcd(m_s);
    e.mode = 2'(m_mode); e.tick = r1;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic mode_pulse();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic inc_pulses(input int n);
    for (int k = 0; k < n; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic sec_rises(input int n);
    for (int k = 0; k < n; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Assert reset away from the clock edge and check it acts at once.
  task automatic mid_reset();
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_hour", bus.hour_bcd, 8'h00);
    check("rst_min",  bus.min_bcd,  8'h00);
    check("rst_sec",  bus.sec_bcd,  8'h00);
    check("rst_mode", {6'd0, bus.mode}, 8'h00);
    check("rst_tick", {7'd0, bus.tick}, 8'h00);
    model_reset();
    rst_n = 1'b1;
  endtask

  // Monitor: every cycle the DUT presents new outputs, compare with the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (bus.hour_bcd === e.h && bus.min_bcd === e.m && bus.sec_bcd === e.s &&
            bus.mode === e.mode && bus.tick === e.tick)
          n_pass++;
        else
          $display("FAIL outputs: got %h:%h:%h mode=%0d tick=%0d, required %h:%h:%h mode=%0d tick=%0d",
                   bus.hour_bcd, bus.min_bcd, bus.sec_bcd, bus.mode, bus.tick,
                   e.h, e.m, e.s, e.mode, e.tick);
      end
    end
  end

  initial begin
    int ticks;
    logic e1, e5, bm, bi;
    rst_n = 1'b0;
    bus.ena_1hz = 1'b0; bus.ena_5hz = 1'b0; bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check("init_hour", bus.hour_bcd, 8'h00);
    check("init_sec",  bus.sec_bcd,  8'h00);
    check("init_mode", {6'd0, bus.mode}, 8'h00);
    check("init_tick", {7'd0, bus.tick}, 8'h00);
    rst_n = 1'b1;

    // Set sequence: hour 05, minute 04 via auto-repeat, seconds cleared on exit.
    sec_rises(3);
    check("run_sec", bus.sec_bcd, 8'h03);
    mode_pulse();
    inc_pulses(5);
    check("set_hour5", bus.hour_bcd, 8'h05);
    check("set_mode1", {6'd0, bus.mode}, 8'h01);
    mode_pulse();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("set_min4", bus.min_bcd, 8'h04);
    check("set_sec_hold", bus.sec_bcd, 8'h03);
    mode_pulse();
    check("exit_mode", {6'd0, bus.mode}, 8'h00);
    check("exit_sec", bus.sec_bcd, 8'h00);

    // Set wraps, leaving the clock at 23:59:00.
    mode_pulse();
    inc_pulses(18);
    check("hour23", bus.hour_bcd, 8'h23);
    inc_pulses(1);
    check("hour_wrap", bus.hour_bcd, 8'h00);
    inc_pulses(23);
    mode_pulse();
    inc_pulses(55);
    check("min59", bus.min_bcd, 8'h59);
    inc_pulses(1);
    check("min_wrap", bus.min_bcd, 8'h00);
    check("min_wrap_hour", bus.hour_bcd, 8'h23);
    inc_pulses(59);
    mode_pulse();

    // Full rollover in one step.
    sec_rises(59);
    check("pre_roll_hour", bus.hour_bcd, 8'h23);
    check("pre_roll_min",  bus.min_bcd,  8'h59);
    check("pre_roll_sec",  bus.sec_bcd,  8'h59);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("roll_hour", bus.hour_bcd, 8'h00);
    check("roll_min",  bus.min_bcd,  8'h00);
    check("roll_sec",  bus.sec_bcd,  8'h00);
    check("roll_tick", {7'd0, bus.tick}, 8'h01);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("roll_tick_end", {7'd0, bus.tick}, 8'h00);

    // Mode edge coincident with a 1 Hz edge at 00:00:59.
    sec_rises(59);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("coll_min",  bus.min_bcd, 8'h01);
    check("coll_sec",  bus.sec_bcd, 8'h00);
    check("coll_mode", {6'd0, bus.mode}, 8'h01);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Time frozen in SET_HOUR while tick keeps pulsing.
    ticks = 0;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (bus.tick === 1'b1) ticks++;
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (bus.tick === 1'b1) ticks++;
    end
    check("pause_ticks", 8'(ticks), 8'd3);
    check("pause_sec", bus.sec_bcd, 8'h00);
    check("pause_min", bus.min_bcd, 8'h01);

    // Reset in the middle of a set state.
    mid_reset();

    // Randomized traffic with occasional mid-cycle resets.
    e1 = 1'b0; e5 = 1'b0; bm = 1'b0; bi = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0)  e1 = ~e1;
      if ($urandom_range(0, 1) == 0)  e5 = ~e5;
      if ($urandom_range(0, 15) == 0) bm = ~bm;
      if ($urandom_range(0, 5) == 0)  bi = ~bi;
      step(e1, e5, bm, bi);
      if ($urandom_range(0, 299) == 0) mid_reset();
    end

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
